// File: rtl/conv_cfg_bank.sv
// conv_cfg_bank: double-buffered configuration bank for the conv layer.
// Host writes go to a shadow set; a commit validates it, derives the output
// feature-map size with an iterative subtract divider and moves it into the
// active set once the conv engine is idle.
module conv_cfg_bank #(
    parameter int KW = 3,
    parameter int IW = 5,
    parameter int SW = 2,
    parameter int NW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [KW-1:0] kernel_size_in,
    input  logic [IW-1:0] img_size_in,
    input  logic [SW-1:0] stride_in,
    input  logic [IW-1:0] width_size_in,
    input  logic [NW-1:0] number_kernel_in,
    input  logic          commit,
    input  logic          engine_busy,
    output logic [KW-1:0] kernel_size_out,
    output logic [IW-1:0] img_size_out,
    output logic [SW-1:0] stride_out,
    output logic [IW-1:0] width_size_out,
    output logic [NW-1:0] number_kernel_out,
    output logic [IW-1:0] out_size_out,
    output logic          cfg_valid,
    output logic          cfg_err,
    output logic          commit_ack,
    output logic          cfg_busy
);

    // Packed configuration word layout: {kernel, img, stride, width, nk}
    localparam int CW    = KW + IW + SW + IW + NW;
    localparam int K_LSB = IW + SW + IW + NW;
    localparam int I_LSB = SW + IW + NW;
    localparam int S_LSB = IW + NW;
    localparam int W_LSB = NW;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_IDLE = 2'd1;
    localparam logic [1:0] S_CALC      = 2'd2;
    localparam logic [1:0] S_APPLY     = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] sh_q, sh_d;
    logic [CW-1:0] wk_q, wk_d;
    logic [CW-1:0] act_q, act_d;
    logic [IW-1:0] rem_q, rem_d;
    logic [IW-1:0] quo_q, quo_d;
    logic [IW-1:0] out_q, out_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          ack_q, ack_d;

    logic [KW-1:0] sh_k, wk_k;
    logic [IW-1:0] sh_img, wk_img, sh_w;
    logic [SW-1:0] sh_s, wk_s;
    logic [NW-1:0] sh_nk;
    logic          sh_legal;

    assign sh_k   = sh_q[K_LSB +: KW];
    assign sh_img = sh_q[I_LSB +: IW];
    assign sh_s   = sh_q[S_LSB +: SW];
    assign sh_w   = sh_q[W_LSB +: IW];
    assign sh_nk  = sh_q[0 +: NW];
    assign wk_k   = wk_q[K_LSB +: KW];
    assign wk_img = wk_q[I_LSB +: IW];
    assign wk_s   = wk_q[S_LSB +: SW];

    // kernel <= img guarantees the divider remainder never underflows
    assign sh_legal = (sh_k != '0) && (sh_s != '0) && (sh_nk != '0) &&
                      (sh_w != '0) && (IW'(sh_k) <= sh_img);

    // Shadow set follows host writes in every state
    assign sh_d = wr_en ? {kernel_size_in, img_size_in, stride_in,
                           width_size_in, number_kernel_in} : sh_q;

    // Commit FSM: validate, wait for idle engine, divide, then apply
    always_comb begin
        state_d = state_q;
        wk_d    = wk_q;
        act_d   = act_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        out_d   = out_q;
        valid_d = valid_q;
        err_d   = err_q;
        ack_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (commit) begin
                    if (!sh_legal) begin
                        err_d = 1'b1;
                    end else begin
                        wk_d  = sh_q;
                        err_d = 1'b0;
                        if (engine_busy) begin
                            state_d = S_WAIT_IDLE;
                        end else begin
                            rem_d   = sh_img - IW'(sh_k);
                            quo_d   = '0;
                            state_d = S_CALC;
                        end
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (!engine_busy) begin
                    rem_d   = wk_img - IW'(wk_k);
                    quo_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (rem_q >= IW'(wk_s)) begin
                    rem_d = rem_q - IW'(wk_s);
                    quo_d = quo_q + IW'(1);
                end else begin
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                act_d   = wk_q;
                out_d   = quo_q + IW'(1);
                valid_d = 1'b1;
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and all register sets; reset aborts any in-flight commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            wk_q    <= '0;
            act_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            wk_q    <= wk_d;
            act_q   <= act_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
        end
    end

    assign kernel_size_out   = act_q[K_LSB +: KW];
    assign img_size_out      = act_q[I_LSB +: IW];
    assign stride_out        = act_q[S_LSB +: SW];
    assign width_size_out    = act_q[W_LSB +: IW];
    assign number_kernel_out = act_q[0 +: NW];
    assign out_size_out      = out_q;
    assign cfg_valid         = valid_q;
    assign cfg_err           = err_q;
    assign commit_ack        = ack_q;
    assign cfg_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_conv_cfg_bank.sv
// Self-checking bench for conv_cfg_bank with a behavioural reference model.
module tb_conv_cfg_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] kernel_size_in = '0;
    logic [4:0] img_size_in = '0;
    logic [1:0] stride_in = '0;
    logic [4:0] width_size_in = '0;
    logic [4:0] number_kernel_in = '0;
    logic       commit = 1'b0;
    logic       engine_busy = 1'b0;
    logic [2:0] kernel_size_out;
    logic [4:0] img_size_out;
    logic [1:0] stride_out;
    logic [4:0] width_size_out;
    logic [4:0] number_kernel_out;
    logic [4:0] out_size_out;
    logic       cfg_valid, cfg_err, commit_ack, cfg_busy;

    conv_cfg_bank dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
        .kernel_size_in(kernel_size_in), .img_size_in(img_size_in),
        .stride_in(stride_in), .width_size_in(width_size_in),
        .number_kernel_in(number_kernel_in), .commit(commit),
        .engine_busy(engine_busy),
        .kernel_size_out(kernel_size_out), .img_size_out(img_size_out),
        .stride_out(stride_out), .width_size_out(width_size_out),
        .number_kernel_out(number_kernel_out), .out_size_out(out_size_out),
        .cfg_valid(cfg_valid), .cfg_err(cfg_err), .commit_ack(commit_ack),
        .cfg_busy(cfg_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int k;
        int img;
        int s;
        int w;
        int nk;
    } cfg_t;

    cfg_t m_sh, m_act;
    int   m_out, m_valid, m_err;
    int   checks = 0;
    int   errors = 0;

    function automatic bit legal(input cfg_t c);
        return c.k != 0 && c.s != 0 && c.nk != 0 && c.w != 0 && c.k <= c.img;
    endfunction

    function automatic cfg_t mk(input int k, input int img, input int s,
                                input int w, input int nk);
        cfg_t c;
        c.k = k; c.img = img; c.s = s; c.w = w; c.nk = nk;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".kernel"}, 32'(kernel_size_out), m_act.k);
        check({tag, ".img"}, 32'(img_size_out), m_act.img);
        check({tag, ".stride"}, 32'(stride_out), m_act.s);
        check({tag, ".width"}, 32'(width_size_out), m_act.w);
        check({tag, ".nk"}, 32'(number_kernel_out), m_act.nk);
        check({tag, ".out_size"}, 32'(out_size_out), m_out);
        check({tag, ".valid"}, 32'(cfg_valid), m_valid);
        check({tag, ".err"}, 32'(cfg_err), m_err);
    endtask

    // Drives a write for the next edge; caller ticks and drops wr_en
    task automatic drive_write(input cfg_t c);
        kernel_size_in   = 3'(c.k);
        img_size_in      = 5'(c.img);
        stride_in        = 2'(c.s);
        width_size_in    = 5'(c.w);
        number_kernel_in = 5'(c.nk);
        wr_en            = 1'b1;
        m_sh             = c;
    endtask

    task automatic write_cfg(input cfg_t c);
        drive_write(c);
        tick();
        wr_en = 1'b0;
    endtask

    function automatic cfg_t rand_legal();
        cfg_t c;
        c.k   = int'($urandom_range(1, 7));
        c.img = int'($urandom_range(c.k, 31));
        c.s   = int'($urandom_range(1, 3));
        c.w   = int'($urandom_range(1, 31));
        c.nk  = int'($urandom_range(1, 31));
        return c;
    endfunction

    function automatic cfg_t rand_illegal();
        cfg_t c;
        c = rand_legal();
        case ($urandom_range(0, 4))
            0: c.k = 0;
            1: c.s = 0;
            2: c.w = 0;
            3: c.nk = 0;
            default: begin
                c.k   = int'($urandom_range(2, 7));
                c.img = int'($urandom_range(0, c.k - 1));
            end
        endcase
        return c;
    endfunction

    // bc: engine_busy edges after the commit edge; mid_wr: write while in flight;
    // same_wr: write in the same cycle as the commit
    task automatic do_commit(input string tag, input int bc, input bit mid_wr, input bit same_wr);
        cfg_t snap;
        int   n, exp_lat, quot;
        snap = m_sh;
        engine_busy = (bc > 0);
        commit = 1'b1;
        if (same_wr) drive_write(rand_legal());
        tick();
        commit = 1'b0;
        wr_en  = 1'b0;
        if (!legal(snap)) begin
            m_err = 1;
            check({tag, ".rej_ack"}, 32'(commit_ack), 0);
            check({tag, ".rej_busy"}, 32'(cfg_busy), 0);
            check_all({tag, ".rej"});
            tick();
            check({tag, ".rej_ack2"}, 32'(commit_ack), 0);
            check_all({tag, ".rej2"});
            engine_busy = 1'b0;
            return;
        end
        m_err = 0;
        check({tag, ".busy"}, 32'(cfg_busy), 1);
        quot = (snap.img - snap.k) / snap.s;
        exp_lat = quot + 2 + ((bc > 0) ? bc + 1 : 0);
        n = 0;
        for (int i = 0; i < bc; i++) begin
            if (i == 2) commit = 1'b1;
            if (i == 4 && mid_wr) drive_write(rand_legal());
            check({tag, ".wait_ack"}, 32'(commit_ack), 0);
            check_all({tag, ".wait"});
            tick();
            n++;
            commit = 1'b0;
            wr_en  = 1'b0;
        end
        engine_busy = 1'b0;
        if (mid_wr && bc == 0) drive_write(rand_legal());
        while (commit_ack !== 1'b1 && n < 200) begin
            tick();
            n++;
            wr_en = 1'b0;
        end
        check({tag, ".latency"}, 32'(n), exp_lat);
        m_act   = snap;
        m_out   = quot + 1;
        m_valid = 1;
        check({tag, ".ack"}, 32'(commit_ack), 1);
        check({tag, ".busy_done"}, 32'(cfg_busy), 0);
        check_all({tag, ".apply"});
        tick();
        check({tag, ".ack_pulse"}, 32'(commit_ack), 0);
        check_all({tag, ".hold"});
    endtask

    initial begin
        m_sh  = mk(0, 0, 0, 0, 0);
        m_act = m_sh;
        m_out = 0; m_valid = 0; m_err = 0;

        #12;
        check_all("reset");
        check("reset.ack", 32'(commit_ack), 0);
        check("reset.busy", 32'(cfg_busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        write_cfg(mk(3, 8, 1, 3, 4));
        tick();
        tick();
        check_all("no_commit");

        do_commit("basic8", 0, 0, 0);
        write_cfg(mk(5, 28, 2, 7, 9));
        do_commit("basic28", 0, 0, 0);

        write_cfg(mk(3, 8, 0, 3, 4));
        do_commit("ill_stride", 0, 0, 0);
        write_cfg(mk(7, 5, 1, 3, 4));
        do_commit("ill_k_gt_img", 0, 0, 0);
        write_cfg(mk(3, 8, 1, 3, 0));
        do_commit("ill_nk", 0, 0, 0);
        write_cfg(mk(2, 16, 3, 12, 20));
        do_commit("clear_err", 0, 0, 0);

        write_cfg(mk(1, 20, 2, 5, 6));
        do_commit("busy10", 10, 1, 0);
        do_commit("after_busy_wr", 0, 0, 0);

        write_cfg(mk(4, 31, 1, 2, 3));
        do_commit("mid_calc_wr", 0, 1, 0);
        do_commit("apply_mid_wr", 0, 0, 0);
        write_cfg(mk(6, 9, 2, 1, 1));
        do_commit("same_cycle_wr", 0, 0, 1);
        do_commit("apply_same_wr", 0, 0, 0);

        for (int r = 0; r < 24; r++) begin
            cfg_t c;
            c = ($urandom_range(0, 4) == 0) ? rand_illegal() : rand_legal();
            write_cfg(c);
            do_commit("rand", int'($urandom_range(0, 1)) * int'($urandom_range(1, 6)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        write_cfg(mk(1, 31, 1, 4, 4));
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (5) tick();
        check("pre_rst.busy", 32'(cfg_busy), 1);
        rst_n = 1'b0;
        #1;
        m_sh  = mk(0, 0, 0, 0, 0);
        m_act = m_sh;
        m_out = 0; m_valid = 0; m_err = 0;
        check_all("mid_rst");
        check("mid_rst.ack", 32'(commit_ack), 0);
        check("mid_rst.busy", 32'(cfg_busy), 0);
        #3 rst_n = 1'b1;
        tick();
        do_commit("post_rst", 0, 0, 0);
        check("post_rst.err", 32'(cfg_err), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
